instruction_fetch: RTL and testbench

//   Instruction-fetch sequencer and producer side of the instruction register's parallel-load interface.
//   - Owns the program counter (PC).
//   - Reads 16-bit instruction words from instruction memory with a rd/ready handshake.
//   - Presents each word on ir_data and pulses load_ir for one cycle, so the IR captures it.
//   - Sits between the CPU control FSM (fetch_go, branch redirect) and instruction memory.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
// master: mem_rd/mem_addr out, mem_rdata/mem_ready in; slave: the mirror image.
interface instruction_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch sequencer: owns the PC, reads words over imem and loads the IR.
// Ports: clk, reset_n, fetch_go, branch_valid/addr, imem (master), ir_data, load_ir, pc, busy, fetch_err.
module instruction_fetch #(
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int          TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fetch_go,
    input  logic                 branch_valid,
    input  logic [ADDR_W-1:0]    branch_addr,
    instruction_fetch_if.master  imem,
    output logic [15:0]          ir_data,
    output logic                 load_ir,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 fetch_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD
    } state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_pc, w_pc;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_rd, w_rd;
    logic [15:0]       r_ir, w_ir;
    logic              r_load, w_load;
    logic              r_err, w_err;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_pend, w_pend;
    logic [ADDR_W-1:0] r_pend_a, w_pend_a;

    // A redirect arriving on the same edge as completion wins over an older one.
    logic              w_redir;
    logic [ADDR_W-1:0] w_redir_a;

    assign w_redir   = branch_valid | r_pend;
    assign w_redir_a = branch_valid ? branch_addr : r_pend_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_pc     <= PC_RST;
            r_addr   <= PC_RST;
            r_rd     <= 1'b0;
            r_ir     <= '0;
            r_load   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_pend_a <= '0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_addr   <= w_addr;
            r_rd     <= w_rd;
            r_ir     <= w_ir;
            r_load   <= w_load;
            r_err    <= w_err;
            r_cnt    <= w_cnt;
            r_pend   <= w_pend;
            r_pend_a <= w_pend_a;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_addr   = r_addr;
        w_rd     = r_rd;
        w_ir     = r_ir;
        w_load   = 1'b0;
        w_err    = 1'b0;
        w_cnt    = r_cnt;
        w_pend   = r_pend;
        w_pend_a = r_pend_a;
        unique case (r_state)
            S_IDLE: begin
                if (fetch_go) begin
                    w_addr  = branch_valid ? branch_addr : r_pc;
                    w_rd    = 1'b1;
                    w_cnt   = '0;
                    w_state = S_WAIT;
                end else if (branch_valid) begin
                    w_pc = branch_addr;
                end
            end
            S_WAIT: begin
                if (branch_valid) begin
                    w_pend   = 1'b1;
                    w_pend_a = branch_addr;
                end
                if (imem.mem_ready) begin
                    w_ir    = imem.mem_rdata;
                    w_load  = 1'b1;
                    w_rd    = 1'b0;
                    w_state = S_LOAD;
                    w_pc    = w_redir ? w_redir_a : r_addr + ADDR_W'(1);
                    w_pend  = 1'b0;
                end else if (r_cnt == LAST) begin
                    w_rd    = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                    w_pend  = 1'b0;
                    if (w_redir) begin
                        w_pc = w_redir_a;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                // The fetch has already retired, so a redirect here lands directly.
                w_state = S_IDLE;
                if (branch_valid) begin
                    w_pc = branch_addr;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign imem.mem_rd   = r_rd;
    assign imem.mem_addr = r_addr;
    assign ir_data       = r_ir;
    assign load_ir       = r_load;
    assign pc            = r_pc;
    assign busy          = (r_state != S_IDLE);
    assign fetch_err     = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Memory model returns tb_mem[mem_addr]; ready is driven per scenario.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        fetch_go;
    logic        branch_valid;
    logic [7:0]  branch_addr;
    logic [15:0] ir_data;
    logic        load_ir;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_err;

    logic [15:0] tb_mem [256];
    int          errors;
    int          checks;

    instruction_fetch_if #(.ADDR_W(8)) bus ();

    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    instruction_fetch #(
        .ADDR_W   (8),
        .RESET_PC (0),
        .TIMEOUT  (15)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_go     (fetch_go),
        .branch_valid (branch_valid),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .ir_data      (ir_data),
        .load_ir      (load_ir),
        .pc           (pc),
        .busy         (busy),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({pc, bus.mem_addr, ir_data} !== {8'h00, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_regs: got pc=%h addr=%h ir=%h want 00 00 0000",
                     pc, bus.mem_addr, ir_data);
        end
        checks++;
        if ({bus.mem_rd, load_ir, busy, fetch_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got rd/ld/busy/err=%b want 0000",
                     {bus.mem_rd, load_ir, busy, fetch_err});
        end
    endtask

    task automatic test_basic_fetch();
        bus.mem_ready = 1'b1;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        checks++;
        if ({bus.mem_rd, bus.mem_addr, load_ir, busy} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_req: got rd=%b addr=%h ld=%b busy=%b want 1 00 0 1",
                     bus.mem_rd, bus.mem_addr, load_ir, busy);
        end
        tick();
        checks++;
        if ({load_ir, bus.mem_rd, ir_data, pc} !== {1'b1, 1'b0, 16'hA5C3, 8'h01}) begin
            errors++;
            $display("FAIL basic_load: got ld=%b rd=%b ir=%h pc=%h want 1 0 a5c3 01",
                     load_ir, bus.mem_rd, ir_data, pc);
        end
        tick();
        checks++;
        if ({load_ir, busy, ir_data} !== {1'b0, 1'b0, 16'hA5C3}) begin
            errors++;
            $display("FAIL basic_done: got ld=%b busy=%b ir=%h want 0 0 a5c3",
                     load_ir, busy, ir_data);
        end
    endtask

    task automatic test_pc_wrap();
        branch_valid = 1'b1;
        branch_addr  = 8'hFF;
        tick();
        branch_valid = 1'b0;
        checks++;
        if ({pc, busy} !== {8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL idle_redirect: got pc=%h busy=%b want ff 0", pc, busy);
        end
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        checks++;
        if (bus.mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_addr: got %h want ff", bus.mem_addr);
        end
        tick();
        checks++;
        if ({pc, ir_data, load_ir} !== {8'h00, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h ir=%h ld=%b want 00 beef 1",
                     pc, ir_data, load_ir);
        end
        tick();
    endtask

    task automatic test_go_with_branch();
        fetch_go     = 1'b1;
        branch_valid = 1'b1;
        branch_addr  = 8'h40;
        tick();
        fetch_go     = 1'b0;
        branch_valid = 1'b0;
        checks++;
        if ({bus.mem_addr, bus.mem_rd} !== {8'h40, 1'b1}) begin
            errors++;
            $display("FAIL gobr_addr: got addr=%h rd=%b want 40 1",
                     bus.mem_addr, bus.mem_rd);
        end
        tick();
        checks++;
        if ({pc, ir_data, load_ir} !== {8'h41, 16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL gobr_load: got pc=%h ir=%h ld=%b want 41 1234 1",
                     pc, ir_data, load_ir);
        end
        tick();
    endtask

    task automatic test_branch_in_wait();
        bus.mem_ready = 1'b0;
        fetch_go = 1'b1;
        tick();
        fetch_go     = 1'b0;
        branch_valid = 1'b1;
        branch_addr  = 8'h10;
        tick();
        branch_valid = 1'b0;
        checks++;
        if ({pc, bus.mem_addr, bus.mem_rd} !== {8'h41, 8'h41, 1'b1}) begin
            errors++;
            $display("FAIL pend_hold: got pc=%h addr=%h rd=%b want 41 41 1",
                     pc, bus.mem_addr, bus.mem_rd);
        end
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checks++;
        if ({pc, ir_data, load_ir} !== {8'h10, 16'h5678, 1'b1}) begin
            errors++;
            $display("FAIL pend_apply: got pc=%h ir=%h ld=%b want 10 5678 1",
                     pc, ir_data, load_ir);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n_rd;
        int n_ld;
        int n_err;
        n_rd  = 0;
        n_ld  = 0;
        n_err = 0;
        bus.mem_ready = 1'b0;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.mem_rd)  n_rd++;
            if (load_ir)     n_ld++;
            if (fetch_err)   n_err++;
            tick();
        end
        checks++;
        if (n_rd !== 15) begin
            errors++;
            $display("FAIL tmo_rd_cycles: got %0d want 15", n_rd);
        end
        checks++;
        if ({n_ld, n_err} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL tmo_pulses: got load=%0d err=%0d want 0 1", n_ld, n_err);
        end
        checks++;
        if ({pc, ir_data, busy} !== {8'h10, 16'h5678, 1'b0}) begin
            errors++;
            $display("FAIL tmo_state: got pc=%h ir=%h busy=%b want 10 5678 0",
                     pc, ir_data, busy);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bus.mem_ready = 1'b0;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rd, busy, load_ir, fetch_err} !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst_flags: got rd/busy/ld/err=%b want 0000",
                     {bus.mem_rd, busy, load_ir, fetch_err});
        end
        checks++;
        if ({pc, bus.mem_addr, ir_data} !== {8'h00, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL async_rst_regs: got pc=%h addr=%h ir=%h want 00 00 0000",
                     pc, bus.mem_addr, ir_data);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_go_in_wait();
        int n_ld;
        n_ld = 0;
        bus.mem_ready = 1'b0;
        branch_valid  = 1'b1;
        branch_addr   = 8'h40;
        tick();
        branch_valid  = 1'b0;
        fetch_go = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.mem_addr, bus.mem_rd, busy} !== {8'h40, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL go_wait_addr: got addr=%h rd=%b busy=%b want 40 1 1",
                     bus.mem_addr, bus.mem_rd, busy);
        end
        fetch_go      = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (load_ir) n_ld++;
        end
        bus.mem_ready = 1'b0;
        checks++;
        if ({n_ld, bus.mem_rd, busy, pc} !== {32'd1, 1'b0, 1'b0, 8'h41}) begin
            errors++;
            $display("FAIL go_wait_once: got loads=%0d rd=%b busy=%b pc=%h want 1 0 0 41",
                     n_ld, bus.mem_rd, busy, pc);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        fetch_go      = 1'b0;
        branch_valid  = 1'b0;
        branch_addr   = 8'h00;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
        tb_mem[8'h00] = 16'hA5C3;
        tb_mem[8'hFF] = 16'hBEEF;
        tb_mem[8'h40] = 16'h1234;
        tb_mem[8'h41] = 16'h5678;
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_basic_fetch();
        test_pc_wrap();
        test_go_with_branch();
        test_branch_in_wait();
        test_timeout();
        test_reset_mid_fetch();
        test_go_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
